// File: rtl/prog_ctr.sv
// ---------------------------------------------------------------------------
// prog_ctr -- program counter and run/halt sequencer for a small microcoded
// engine. Produces the instruction-ROM fetch address each cycle, tracks the
// IDLE/RUN/HALT execution state and counts the cycles spent running.
//
// Parameters
//   D   : program-counter width (instruction ROM address width)
//   OW  : signed relative-branch offset width
//   CW  : cycle-counter width
//
// Ports
//   Clk       in   single clock, all state changes on the rising edge
//   Reset_n   in   asynchronous active-low reset
//   Start     in   begin execution at address 0 (from IDLE or HALT)
//   Halt      in   decoded halt instruction, stop fetching
//   Stall     in   hold the current fetch address for this cycle
//   AbsJump   in   unconditional jump to Target
//   Target    in   absolute jump address [D]
//   RelJump   in   conditional relative branch present
//   Taken     in   branch condition true (qualifies RelJump)
//   Offset    in   two's-complement branch offset [OW]
//   PrgCtr    out  fetch address [D]
//   Running   out  high while in RUN
//   Done      out  high while in HALT
//   CycleCnt  out  saturating count of RUN cycles for this program [CW]
// ---------------------------------------------------------------------------
module prog_ctr #(
    parameter int D  = 12,
    parameter int OW = 8,
    parameter int CW = 16
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          Start,
    input  logic          Halt,
    input  logic          Stall,
    input  logic          AbsJump,
    input  logic [D-1:0]  Target,
    input  logic          RelJump,
    input  logic          Taken,
    input  logic [OW-1:0] Offset,
    output logic [D-1:0]  PrgCtr,
    output logic          Running,
    output logic          Done,
    output logic [CW-1:0] CycleCnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [D-1:0]  pc_next;
    logic [CW-1:0] cnt_next;
    logic [D-1:0]  offset_ext;
    logic          cnt_full;

    // Sign-extend (or truncate) the offset to PC width; the add below then
    // wraps modulo 2^D in both directions for free.
    assign offset_ext = D'($signed(Offset));
    assign cnt_full   = &CycleCnt;

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        pc_next    = PrgCtr;
        cnt_next   = CycleCnt;

        case (state)
            IDLE: begin
                if (Start) begin
                    state_next = RUN;
                    pc_next    = '0;
                    cnt_next   = '0;
                end
            end

            RUN: begin
                // Every RUN cycle counts, including stalls and the cycle in
                // which Halt is seen.
                cnt_next = cnt_full ? CycleCnt : CycleCnt + CW'(1);

                if (Halt) begin
                    state_next = HALT;          // PC keeps the halt address
                end else if (Stall) begin
                    pc_next = PrgCtr;
                end else if (AbsJump) begin
                    pc_next = Target;
                end else if (RelJump && Taken) begin
                    pc_next = PrgCtr + offset_ext;
                end else begin
                    pc_next = PrgCtr + D'(1);
                end
            end

            HALT: begin
                if (Start) begin
                    state_next = RUN;
                    pc_next    = '0;
                    cnt_next   = '0;
                end
            end

            default: begin
                state_next = IDLE;
                pc_next    = '0;
                cnt_next   = '0;
            end
        endcase
    end

    // Running/Done are flopped from the next state so every output comes
    // straight from a register.
    // NOTE: sequential state uses non-blocking assignments so all flops
    // update together from the same pre-edge values.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            PrgCtr   <= '0;
            CycleCnt <= '0;
            Running  <= 1'b0;
            Done     <= 1'b0;
        end else begin
            state    <= state_next;
            PrgCtr   <= pc_next;
            CycleCnt <= cnt_next;
            Running  <= (state_next == RUN);
            Done     <= (state_next == HALT);
        end
    end

endmodule

// File: tb/tb_prog_ctr.sv
// ---------------------------------------------------------------------------
// tb_prog_ctr -- directed self-checking bench for prog_ctr. A second instance
// with a 4-bit cycle counter shares all inputs so counter saturation can be
// observed in a few cycles.
// ---------------------------------------------------------------------------
module tb_prog_ctr;

    logic        Clk;
    logic        Reset_n;
    logic        Start;
    logic        Halt;
    logic        Stall;
    logic        AbsJump;
    logic [11:0] Target;
    logic        RelJump;
    logic        Taken;
    logic [7:0]  Offset;
    logic [11:0] PrgCtr;
    logic        Running;
    logic        Done;
    logic [15:0] CycleCnt;

    logic [11:0] sat_pc;
    logic        sat_running;
    logic        sat_done;
    logic [3:0]  sat_cnt;

    int total = 0;
    int bad   = 0;

    prog_ctr dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Halt(Halt),
        .Stall(Stall), .AbsJump(AbsJump), .Target(Target),
        .RelJump(RelJump), .Taken(Taken), .Offset(Offset),
        .PrgCtr(PrgCtr), .Running(Running), .Done(Done), .CycleCnt(CycleCnt)
    );

    prog_ctr #(.D(12), .OW(8), .CW(4)) dut_sat (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Halt(Halt),
        .Stall(Stall), .AbsJump(AbsJump), .Target(Target),
        .RelJump(RelJump), .Taken(Taken), .Offset(Offset),
        .PrgCtr(sat_pc), .Running(sat_running), .Done(sat_done), .CycleCnt(sat_cnt)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic clear_inputs();
        Start   = 1'b0;
        Halt    = 1'b0;
        Stall   = 1'b0;
        AbsJump = 1'b0;
        Target  = '0;
        RelJump = 1'b0;
        Taken   = 1'b0;
        Offset  = '0;
    endtask

    // Advance one clock and sample 1 ns after the rising edge.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        Reset_n = 1'b1;
        #2 Reset_n = 1'b0;
        #1;
        total++;
        if (PrgCtr !== 12'd0 || Running !== 1'b0 || Done !== 1'b0 || CycleCnt !== 16'd0) begin
            bad++;
            $display("FAIL reset_state: pc=%h run=%b done=%b cnt=%0d want pc=000 run=0 done=0 cnt=0", PrgCtr, Running, Done, CycleCnt);
        end
        step();
        Reset_n = 1'b1;
        // Everything but Start must be ignored in IDLE.
        Halt = 1'b1; Stall = 1'b1; AbsJump = 1'b1; Target = 12'h055;
        RelJump = 1'b1; Taken = 1'b1; Offset = 8'h10;
        repeat (3) step();
        total++;
        if (PrgCtr !== 12'd0 || Running !== 1'b0 || Done !== 1'b0 || CycleCnt !== 16'd0) begin
            bad++;
            $display("FAIL idle_ignores: pc=%h run=%b done=%b cnt=%0d want pc=000 run=0 done=0 cnt=0", PrgCtr, Running, Done, CycleCnt);
        end
        clear_inputs();
    endtask

    task automatic test_sequential();
        Start = 1'b1;
        step();
        Start = 1'b0;
        total++;
        if (PrgCtr !== 12'd0 || Running !== 1'b1 || Done !== 1'b0 || CycleCnt !== 16'd0) begin
            bad++;
            $display("FAIL start: pc=%h run=%b done=%b cnt=%0d want pc=000 run=1 done=0 cnt=0", PrgCtr, Running, Done, CycleCnt);
        end
        for (int i = 1; i <= 5; i++) begin
            step();
            total++;
            if (PrgCtr !== 12'(i)) begin
                bad++;
                $display("FAIL seq_pc: pc=%h want %h", PrgCtr, 12'(i));
            end
        end
        total++;
        if (Running !== 1'b1 || CycleCnt !== 16'd5) begin
            bad++;
            $display("FAIL seq_cnt: run=%b cnt=%0d want run=1 cnt=5", Running, CycleCnt);
        end
    endtask

    task automatic test_branch();
        repeat (5) step();
        total++;
        if (PrgCtr !== 12'd10 || CycleCnt !== 16'd10) begin
            bad++;
            $display("FAIL pre_branch: pc=%h cnt=%0d want pc=00a cnt=10", PrgCtr, CycleCnt);
        end
        RelJump = 1'b1; Taken = 1'b1; Offset = 8'hFC;
        step();
        total++;
        if (PrgCtr !== 12'd6) begin
            bad++;
            $display("FAIL rel_taken: pc=%h want 006", PrgCtr);
        end
        Taken = 1'b0;
        step();
        total++;
        if (PrgCtr !== 12'd7) begin
            bad++;
            $display("FAIL rel_not_taken: pc=%h want 007", PrgCtr);
        end
        RelJump = 1'b0; AbsJump = 1'b1; Target = 12'h3FF;
        step();
        total++;
        if (PrgCtr !== 12'h3FF || CycleCnt !== 16'd13) begin
            bad++;
            $display("FAIL abs_jump: pc=%h cnt=%0d want pc=3ff cnt=13", PrgCtr, CycleCnt);
        end
        // Start while running must not restart the program.
        clear_inputs();
        Start = 1'b1;
        step();
        Start = 1'b0;
        total++;
        if (PrgCtr !== 12'h400 || Running !== 1'b1 || CycleCnt !== 16'd14) begin
            bad++;
            $display("FAIL start_in_run: pc=%h run=%b cnt=%0d want pc=400 run=1 cnt=14", PrgCtr, Running, CycleCnt);
        end
    endtask

    task automatic test_wrap();
        AbsJump = 1'b1; Target = 12'hFFF;
        step();
        AbsJump = 1'b0;
        total++;
        if (PrgCtr !== 12'hFFF) begin
            bad++;
            $display("FAIL wrap_load: pc=%h want fff", PrgCtr);
        end
        step();
        total++;
        if (PrgCtr !== 12'h000) begin
            bad++;
            $display("FAIL inc_wrap: pc=%h want 000", PrgCtr);
        end
        RelJump = 1'b1; Taken = 1'b1; Offset = 8'hFF;
        step();
        total++;
        if (PrgCtr !== 12'hFFF) begin
            bad++;
            $display("FAIL rel_wrap_down: pc=%h want fff", PrgCtr);
        end
        Offset = 8'h05;
        step();
        total++;
        if (PrgCtr !== 12'h004 || CycleCnt !== 16'd18) begin
            bad++;
            $display("FAIL rel_wrap_up: pc=%h cnt=%0d want pc=004 cnt=18", PrgCtr, CycleCnt);
        end
        clear_inputs();
    endtask

    task automatic test_stall();
        AbsJump = 1'b1; Target = 12'd4;
        step();
        clear_inputs();
        total++;
        if (PrgCtr !== 12'd4 || CycleCnt !== 16'd19) begin
            bad++;
            $display("FAIL stall_setup: pc=%h cnt=%0d want pc=004 cnt=19", PrgCtr, CycleCnt);
        end
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            // Mid-stall, jumps and branches must lose to Stall.
            AbsJump = (i == 1); Target = 12'h077;
            RelJump = (i == 2); Taken = 1'b1; Offset = 8'h10;
            step();
            total++;
            if (PrgCtr !== 12'd4) begin
                bad++;
                $display("FAIL stall_hold: cycle %0d pc=%h want 004", i, PrgCtr);
            end
        end
        clear_inputs();
        total++;
        if (CycleCnt !== 16'd22 || Running !== 1'b1) begin
            bad++;
            $display("FAIL stall_cnt: cnt=%0d run=%b want cnt=22 run=1", CycleCnt, Running);
        end
        step();
        step();
        total++;
        if (PrgCtr !== 12'd6 || CycleCnt !== 16'd24) begin
            bad++;
            $display("FAIL stall_resume: pc=%h cnt=%0d want pc=006 cnt=24", PrgCtr, CycleCnt);
        end
    endtask

    task automatic test_priority();
        AbsJump = 1'b1; Target = 12'd20;
        step();
        Halt = 1'b1; Stall = 1'b1; Target = 12'd100;
        step();
        clear_inputs();
        total++;
        if (PrgCtr !== 12'd20 || Done !== 1'b1 || Running !== 1'b0 || CycleCnt !== 16'd26) begin
            bad++;
            $display("FAIL halt_priority: pc=%h done=%b run=%b cnt=%0d want pc=014 done=1 run=0 cnt=26", PrgCtr, Done, Running, CycleCnt);
        end
        RelJump = 1'b1; Taken = 1'b1; Offset = 8'h03;
        step();
        step();
        clear_inputs();
        total++;
        if (PrgCtr !== 12'd20 || Done !== 1'b1 || CycleCnt !== 16'd26) begin
            bad++;
            $display("FAIL halt_hold: pc=%h done=%b cnt=%0d want pc=014 done=1 cnt=26", PrgCtr, Done, CycleCnt);
        end
        Start = 1'b1;
        step();
        Start = 1'b0;
        total++;
        if (PrgCtr !== 12'd0 || Done !== 1'b0 || Running !== 1'b1 || CycleCnt !== 16'd0) begin
            bad++;
            $display("FAIL restart: pc=%h done=%b run=%b cnt=%0d want pc=000 done=0 run=1 cnt=0", PrgCtr, Done, Running, CycleCnt);
        end
    endtask

    task automatic test_saturate();
        repeat (20) step();
        total++;
        if (sat_cnt !== 4'd15 || CycleCnt !== 16'd20 || PrgCtr !== 12'd20) begin
            bad++;
            $display("FAIL cnt_saturate: narrow=%0d wide=%0d pc=%h want narrow=15 wide=20 pc=014", sat_cnt, CycleCnt, PrgCtr);
        end
    endtask

    task automatic test_async_reset();
        AbsJump = 1'b1; Target = 12'd9;
        step();
        clear_inputs();
        total++;
        if (PrgCtr !== 12'd9 || Running !== 1'b1) begin
            bad++;
            $display("FAIL reset_setup: pc=%h run=%b want pc=009 run=1", PrgCtr, Running);
        end
        #3;
        Start   = 1'b1;
        Reset_n = 1'b0;
        #1;  // still well before the next rising edge
        total++;
        if (PrgCtr !== 12'd0 || Running !== 1'b0 || Done !== 1'b0 || CycleCnt !== 16'd0) begin
            bad++;
            $display("FAIL async_reset: pc=%h run=%b done=%b cnt=%0d want all 0", PrgCtr, Running, Done, CycleCnt);
        end
        step();
        total++;
        if (PrgCtr !== 12'd0 || Running !== 1'b0 || CycleCnt !== 16'd0) begin
            bad++;
            $display("FAIL start_in_reset: pc=%h run=%b cnt=%0d want all 0", PrgCtr, Running, CycleCnt);
        end
        #2;
        Reset_n = 1'b1;
        Start   = 1'b0;
        step();
        step();
        total++;
        if (Running !== 1'b0 || Done !== 1'b0 || PrgCtr !== 12'd0) begin
            bad++;
            $display("FAIL post_reset_idle: pc=%h run=%b done=%b want pc=000 run=0 done=0", PrgCtr, Running, Done);
        end
        Start = 1'b1;
        step();
        Start = 1'b0;
        step();
        total++;
        if (PrgCtr !== 12'd1 || Running !== 1'b1 || CycleCnt !== 16'd1) begin
            bad++;
            $display("FAIL post_reset_run: pc=%h run=%b cnt=%0d want pc=001 run=1 cnt=1", PrgCtr, Running, CycleCnt);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_wrap();
        test_stall();
        test_priority();
        test_saturate();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
